// File: rtl/throttle_pkg.sv
// Shared definitions for the multi-channel LFSR stream throttle:
// mode codes, APB word map and Galois LFSR tap sets.
package throttle_pkg;

   typedef enum logic [1:0] {
      MODE_RANDOM   = 2'd0,
      MODE_PERIODIC = 2'd1,
      MODE_BURST    = 2'd2,
      MODE_BYPASS   = 2'd3
   } mode_e;

   localparam logic [5:0] W_STATUS  = 6'd0;
   localparam logic [5:0] W_CTRL    = 6'd1;
   localparam logic [5:0] CH_BASE   = 6'd4;
   localparam logic [5:0] CH_STRIDE = 6'd4;

   localparam logic [1:0] OFF_RATE = 2'd0;
   localparam logic [1:0] OFF_MODE = 2'd1;
   localparam logic [1:0] OFF_BLEN = 2'd2;
   localparam logic [1:0] OFF_CNT  = 2'd3;

   localparam logic [15:0] TAPS16 = 16'hB400;
   localparam logic [31:0] TAPS32 = 32'h80200003;

   function automatic logic [31:0] lfsr_taps(input int bits);
      return (bits == 32) ? TAPS32 : {16'h0, TAPS16};
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR that advances one step when step is high.
// Ports: clk, rst_n (async low), step (advance), q (current state).
module lfsr_galois
   import throttle_pkg::*;
#(
   parameter int              Bits = 16,
   parameter logic [Bits-1:0] Seed = Bits'(1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step,
   output logic [Bits-1:0] q
);

   localparam logic [Bits-1:0] TAPS = Bits'(lfsr_taps(Bits));
   // All-zero is the lock-up state, so it is never used as a seed.
   localparam logic [Bits-1:0] SEED_NZ =
      (Seed == '0) ? Bits'(1) : Seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED_NZ;
      end else if (step) begin
         q <= {1'b0, q[Bits-1:1]} ^ (q[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/lfsr_throttle_mc.sv
// Multi-channel valid/ready throttle with per-channel pass decisions.
// Ports: clk, rst_n, APB cfg_* slave, din_*/dout_* stream pairs.
module lfsr_throttle_mc
   import throttle_pkg::*;
#(
   parameter int NumChannels = 2,
   parameter int RateBits    = 8,
   parameter int LfsrBits    = 16,
   parameter int Seed        = 1,
   parameter int RateDefault = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             cfg_paddr,
   input  logic                   cfg_pwrite,
   input  logic                   cfg_psel,
   input  logic                   cfg_penable,
   input  logic [31:0]            cfg_pwdata,
   output logic                   cfg_pready,
   output logic [31:0]            cfg_prdata,
   output logic                   cfg_pslverr,
   input  logic [NumChannels-1:0] din_valid,
   output logic [NumChannels-1:0] din_ready,
   output logic [NumChannels-1:0] dout_valid,
   input  logic [NumChannels-1:0] dout_ready
);

   localparam logic [5:0] NCH = 6'(NumChannels);

   logic                r_en;
   logic [RateBits-1:0] r_rate [NumChannels];
   mode_e               r_mode [NumChannels];
   logic [7:0]          r_blen [NumChannels];
   logic [31:0]         r_prdata;

   logic [5:0]  w_word;
   logic [5:0]  w_rel;
   logic [5:0]  w_chw;
   logic [1:0]  w_off;
   logic        w_hit;
   logic        w_acc;
   logic        w_wr;
   logic        w_rd;
   logic        w_clr;
   logic [31:0] w_rdata;
   logic        w_unused;

   logic [NumChannels-1:0][31:0] w_cnt;
   logic [4*NumChannels-1:0]     w_status;

   assign cfg_pready  = 1'b1;
   assign cfg_pslverr = 1'b0;
   assign cfg_prdata  = r_prdata;

   assign w_unused = ^{cfg_paddr[1:0], cfg_pwdata};

   assign w_word = cfg_paddr[7:2];
   assign w_rel  = w_word - CH_BASE;
   assign w_chw  = w_rel / CH_STRIDE;
   assign w_off  = w_rel[1:0];
   assign w_hit  = (w_word >= CH_BASE) && (w_chw < NCH);
   assign w_acc  = cfg_psel & ~cfg_penable;
   assign w_wr   = w_acc & cfg_pwrite;
   assign w_rd   = w_acc & ~cfg_pwrite;
   assign w_clr  = w_wr && (w_word == W_CTRL) && cfg_pwdata[1];

   assign w_status = {dout_ready, dout_valid, din_ready, din_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en <= 1'b1;
         for (int c = 0; c < NumChannels; c++) begin
            r_rate[c] <= RateBits'(RateDefault);
            r_mode[c] <= MODE_RANDOM;
            r_blen[c] <= 8'd1;
         end
      end else if (w_wr) begin
         if (w_word == W_CTRL) begin
            r_en <= cfg_pwdata[0];
         end
         for (int c = 0; c < NumChannels; c++) begin
            if (w_hit && w_chw == 6'(c)) begin
               case (w_off)
                  OFF_RATE: r_rate[c] <= cfg_pwdata[RateBits-1:0];
                  OFF_MODE: r_mode[c] <= mode_e'(cfg_pwdata[1:0]);
                  OFF_BLEN: r_blen[c] <= cfg_pwdata[7:0];
                  default:  ;
               endcase
            end
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_word == W_STATUS) begin
         w_rdata = 32'(w_status);
      end else if (w_word == W_CTRL) begin
         w_rdata = {31'b0, r_en};
      end
      for (int c = 0; c < NumChannels; c++) begin
         if (w_hit && w_chw == 6'(c)) begin
            case (w_off)
               OFF_RATE: w_rdata = 32'(r_rate[c]);
               OFF_MODE: w_rdata = 32'(r_mode[c]);
               OFF_BLEN: w_rdata = 32'(r_blen[c]);
               default:  w_rdata = w_cnt[c];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prdata <= '0;
      end else if (w_rd) begin
         r_prdata <= w_rdata;
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      localparam logic [LfsrBits-1:0] SEED_C = LfsrBits'(Seed + c);

      logic                r_active;
      logic [RateBits-1:0] r_acc;
      logic [7:0]          r_bcnt;
      mode_e               r_lmode;
      logic [31:0]         r_cnt;

      logic [LfsrBits-1:0] w_lfsr;
      logic                w_xfer;
      logic                w_eval;
      logic                w_mchg;
      logic [RateBits-1:0] w_acc0;
      logic [7:0]          w_b0;
      logic [RateBits:0]   w_sum;
      logic                w_rnd;
      logic                w_per;
      logic                w_pass;
      logic [RateBits-1:0] w_acc_n;
      logic [7:0]          w_b_n;
      logic                w_unused_lfsr;

      assign dout_valid[c] = r_active & din_valid[c];
      assign din_ready[c]  = r_active & dout_ready[c];
      assign w_xfer        = din_valid[c] & din_ready[c];
      // Decisions are only taken when nothing is offered downstream,
      // so a presented beat is never retracted.
      assign w_eval        = ~r_active | w_xfer;
      assign w_cnt[c]      = r_cnt;
      assign w_unused_lfsr = ^w_lfsr;

      lfsr_galois #(
         .Bits (LfsrBits),
         .Seed (SEED_C)
      ) u_lfsr (
         .clk   (clk),
         .rst_n (rst_n),
         .step  (w_eval),
         .q     (w_lfsr)
      );

      always_comb begin
         w_mchg  = r_mode[c] != r_lmode;
         w_acc0  = w_mchg ? '0 : r_acc;
         w_b0    = w_mchg ? '0 : r_bcnt;
         w_sum   = {1'b0, w_acc0} + {1'b0, r_rate[c]};
         w_rnd   = (r_rate[c] == '0) ? 1'b0 :
                   (r_rate[c] == '1) ? 1'b1 :
                   (w_lfsr[RateBits-1:0] <= r_rate[c]);
         w_per   = (r_rate[c] == '0) ? 1'b0 :
                   (r_rate[c] == '1) ? 1'b1 :
                   w_sum[RateBits];
         w_pass  = 1'b0;
         w_acc_n = w_acc0;
         w_b_n   = w_b0;
         if (r_en) begin
            unique case (r_mode[c])
               MODE_RANDOM: w_pass = w_rnd;
               MODE_PERIODIC: begin
                  w_pass  = w_per;
                  w_acc_n = w_sum[RateBits-1:0];
               end
               MODE_BURST: begin
                  if (w_b0 != 8'd0) begin
                     w_pass = 1'b1;
                     if (w_xfer) w_b_n = w_b0 - 8'd1;
                  end else begin
                     w_pass = w_rnd;
                     if (w_rnd) begin
                        w_b_n = (r_blen[c] == 8'd0) ?
                                8'd0 : r_blen[c] - 8'd1;
                     end
                  end
               end
               MODE_BYPASS: w_pass = 1'b1;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_active <= 1'b0;
            r_acc    <= '0;
            r_bcnt   <= '0;
            r_lmode  <= MODE_RANDOM;
         end else if (w_eval) begin
            r_active <= w_pass;
            r_acc    <= w_acc_n;
            r_bcnt   <= w_b_n;
            r_lmode  <= r_mode[c];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_clr) begin
            r_cnt <= '0;
         end else if (w_xfer && r_cnt != '1) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_throttle_mc.sv
// Randomized bench for lfsr_throttle_mc against a behavioural model.
// Directed phases pin the model with hand-derived expectations.
module tb_lfsr_throttle_mc;

   localparam int N    = 2;
   localparam int MASK = 255;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   cfg_paddr;
   logic         cfg_pwrite, cfg_psel, cfg_penable;
   logic [31:0]  cfg_pwdata;
   logic         cfg_pready;
   logic [31:0]  cfg_prdata;
   logic         cfg_pslverr;
   logic [N-1:0] din_valid, din_ready, dout_valid, dout_ready;

   lfsr_throttle_mc #(
      .NumChannels (N),
      .RateBits    (8),
      .LfsrBits    (16),
      .Seed        (1),
      .RateDefault (128)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_paddr   (cfg_paddr),
      .cfg_pwrite  (cfg_pwrite),
      .cfg_psel    (cfg_psel),
      .cfg_penable (cfg_penable),
      .cfg_pwdata  (cfg_pwdata),
      .cfg_pready  (cfg_pready),
      .cfg_prdata  (cfg_prdata),
      .cfg_pslverr (cfg_pslverr),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   bit          m_act   [N];
   int unsigned m_lfsr  [N];
   int unsigned m_acc   [N];
   int unsigned m_bc    [N];
   int unsigned m_lmode [N];
   int unsigned m_cnt   [N];
   int unsigned m_rate  [N];
   int unsigned m_mode  [N];
   int unsigned m_blen  [N];
   bit          m_en;
   int unsigned m_prdata;

   bit watch_hold = 0;
   int drop = 0;
   int adj = 0, run = 0, runs = 0, bad4 = 0, maxrun = 0;
   bit prev0 = 0;

   task automatic chk(input string nm, input int unsigned act,
                      input int unsigned exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int c = 0; c < N; c++) begin
         m_act[c]   = 0;
         m_lfsr[c]  = (1 + c) & 32'hFFFF;
         if (m_lfsr[c] == 0) m_lfsr[c] = 1;
         m_acc[c]   = 0;
         m_bc[c]    = 0;
         m_lmode[c] = 0;
         m_cnt[c]   = 0;
         m_rate[c]  = 128;
         m_mode[c]  = 0;
         m_blen[c]  = 1;
      end
      m_en = 1;
      m_prdata = 0;
   endtask

   function automatic int unsigned m_read(input int unsigned word);
      int unsigned st;
      int c;
      if (word == 0) begin
         st = 0;
         for (int k = 0; k < N; k++) begin
            st |= 32'(din_valid[k]) << k;
            st |= 32'(m_act[k] & dout_ready[k]) << (N + k);
            st |= 32'(m_act[k] & din_valid[k]) << (2 * N + k);
            st |= 32'(dout_ready[k]) << (3 * N + k);
         end
         return st;
      end
      if (word == 1) return 32'(m_en);
      if (word >= 4 && (word - 4) / 4 < N) begin
         c = int'((word - 4) / 4);
         case (word % 4)
            0:       return m_rate[c];
            1:       return m_mode[c];
            2:       return m_blen[c];
            default: return m_cnt[c];
         endcase
      end
      return 0;
   endfunction

   function automatic bit rand_rule(input int c);
      if (m_rate[c] == 0) return 0;
      if (m_rate[c] == MASK) return 1;
      return (m_lfsr[c] & MASK) <= m_rate[c];
   endfunction

   // Advances the model over one rising edge using the driven inputs.
   task automatic m_edge();
      bit acc_ph, wr, rd, clr, xf, p;
      int unsigned word, d, rv, a, b;
      acc_ph = cfg_psel && !cfg_penable;
      wr     = acc_ph && cfg_pwrite;
      rd     = acc_ph && !cfg_pwrite;
      word   = 32'(cfg_paddr) >> 2;
      d      = cfg_pwdata;
      rv     = rd ? m_read(word) : m_prdata;
      clr    = wr && word == 1 && d[1];
      for (int c = 0; c < N; c++) begin
         xf = m_act[c] && din_valid[c] && dout_ready[c];
         if (clr) m_cnt[c] = 0;
         else if (xf && m_cnt[c] != 32'hFFFFFFFF) m_cnt[c]++;
         if (!m_act[c] || xf) begin
            a = (m_mode[c] != m_lmode[c]) ? 0 : m_acc[c];
            b = (m_mode[c] != m_lmode[c]) ? 0 : m_bc[c];
            p = 0;
            if (m_en) begin
               case (m_mode[c])
                  0: p = rand_rule(c);
                  1: begin
                     if (m_rate[c] == 0) p = 0;
                     else if (m_rate[c] == MASK) p = 1;
                     else p = (a + m_rate[c]) > MASK;
                     a = (a + m_rate[c]) % 256;
                  end
                  2: begin
                     if (b > 0) begin
                        p = 1;
                        if (xf) b--;
                     end else begin
                        p = rand_rule(c);
                        if (p) b = (m_blen[c] == 0) ? 0 : m_blen[c] - 1;
                     end
                  end
                  default: p = 1;
               endcase
            end
            m_act[c]   = p;
            m_acc[c]   = a;
            m_bc[c]    = b;
            m_lmode[c] = m_mode[c];
            m_lfsr[c]  = (m_lfsr[c] & 1) ?
                         ((m_lfsr[c] >> 1) ^ 32'hB400) : (m_lfsr[c] >> 1);
         end
      end
      if (wr) begin
         if (word == 1) m_en = d[0];
         if (word >= 4 && (word - 4) / 4 < N) begin
            case (word % 4)
               0: m_rate[(word - 4) / 4] = d & MASK;
               1: m_mode[(word - 4) / 4] = d & 3;
               2: m_blen[(word - 4) / 4] = d & 255;
               default: ;
            endcase
         end
      end
      m_prdata = rv;
   endtask

   task automatic stats_reset();
      adj = 0; run = 0; runs = 0; bad4 = 0; maxrun = 0; prev0 = 0;
   endtask

   // Checks outputs before the edge, then steps DUT and model together.
   task automatic cycle();
      logic [N-1:0] edv, edr;
      bit x0;
      #1;
      for (int c = 0; c < N; c++) begin
         edv[c] = m_act[c] & din_valid[c];
         edr[c] = m_act[c] & dout_ready[c];
      end
      chk("dout_valid", 32'(dout_valid), 32'(edv));
      chk("din_ready", 32'(din_ready), 32'(edr));
      chk("prdata", cfg_prdata, m_prdata);
      if (watch_hold && !dout_valid[0]) drop++;
      x0 = edv[0] & dout_ready[0];
      if (x0) begin
         run++;
         if (prev0) adj++;
      end else if (run > 0) begin
         runs++;
         if (run % 4 != 0) bad4++;
         if (run > maxrun) maxrun = run;
         run = 0;
      end
      prev0 = x0;
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic apb_write(input int unsigned a, input int unsigned d);
      cfg_psel = 1; cfg_penable = 0; cfg_pwrite = 1;
      cfg_paddr = 8'(a); cfg_pwdata = d;
      cycle();
      cfg_penable = 1;
      cycle();
      cfg_psel = 0; cfg_penable = 0; cfg_pwrite = 0;
   endtask

   task automatic apb_read(input int unsigned a, output int unsigned v);
      cfg_psel = 1; cfg_penable = 0; cfg_pwrite = 0;
      cfg_paddr = 8'(a); cfg_pwdata = $urandom;
      cycle();
      v = cfg_prdata;
      cfg_penable = 1;
      cycle();
      cfg_psel = 0; cfg_penable = 0;
   endtask

   // Counts ch0 transfers over exactly n edges of the current traffic.
   task automatic measure(input int n, output int unsigned cnt);
      apb_write(4, 3);
      repeat (n - 1) cycle();
      din_valid = '0;
      apb_read(28, cnt);
   endtask

   initial begin
      int unsigned v;
      int unsigned w, d;
      rst_n = 0;
      cfg_paddr = 0; cfg_pwrite = 0; cfg_psel = 0; cfg_penable = 0;
      cfg_pwdata = 0; din_valid = '0; dout_ready = '0;
      m_reset();
      repeat (3) @(negedge clk);
      rst_n = 1;

      din_valid = '1; dout_ready = '1;
      #1;
      chk("rst_dout_valid", 32'(dout_valid), 0);
      chk("rst_din_ready", 32'(din_ready), 0);
      chk("pready", 32'(cfg_pready), 1);
      chk("pslverr", 32'(cfg_pslverr), 0);
      cycle();
      apb_read(16, v);
      chk("rate0_reset", v, 128);
      apb_read(20, v);
      chk("mode0_reset", v, 0);

      apb_write(20, 3);
      apb_write(36, 3);
      dout_ready = '0;
      repeat (3) cycle();
      dout_ready = '1;
      cycle();
      #1;
      chk("bypass_dout_valid", 32'(dout_valid), 3);
      #1;
      rst_n = 0;
      #1;
      chk("async_rst_dout_valid", 32'(dout_valid), 0);
      chk("async_rst_din_ready", 32'(din_ready), 0);
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;

      din_valid = '1; dout_ready = '1;
      apb_write(16, 0);
      repeat (5) cycle();
      measure(1000, v);
      chk("rate0_count", v, 0);
      din_valid = '1;
      apb_write(16, 255);
      repeat (5) cycle();
      measure(1000, v);
      chk("rate255_count", v, 1000);
      din_valid = '1;
      apb_write(16, 127);
      repeat (5) cycle();
      measure(1000, v);
      $display("rate127 transfers: %0d", v);
      chk("rate127_in_range", 32'(v >= 440 && v <= 560), 1);

      din_valid = '1;
      apb_write(16, 64);
      apb_write(20, 1);
      repeat (5) cycle();
      stats_reset();
      measure(256, v);
      chk("periodic64_count", v, 64);
      chk("periodic_adjacent", 32'(adj), 0);

      din_valid = '1;
      apb_write(20, 2);
      apb_write(24, 4);
      apb_write(16, 0);
      repeat (20) cycle();
      stats_reset();
      apb_write(16, 1);
      repeat (1500) cycle();
      apb_write(16, 0);
      repeat (10) cycle();
      din_valid = '0;
      cycle();
      chk("burst4_seen", 32'(runs > 0), 1);
      chk("burst4_run_len", 32'(bad4), 0);

      din_valid = '1;
      apb_write(24, 0);
      repeat (20) cycle();
      stats_reset();
      apb_write(16, 1);
      repeat (1500) cycle();
      apb_write(16, 0);
      repeat (10) cycle();
      din_valid = '0;
      cycle();
      chk("burst0_seen", 32'(runs > 0), 1);
      chk("burst0_short", 32'(maxrun < 4), 1);

      din_valid = '1;
      apb_write(20, 0);
      apb_write(16, 255);
      repeat (5) cycle();
      dout_ready = '0;
      drop = 0;
      watch_hold = 1;
      apb_write(16, 0);
      apb_write(4, 0);
      repeat (16) cycle();
      watch_hold = 0;
      chk("hold_no_drop", 32'(drop), 0);
      dout_ready = '1;
      cycle();
      #1;
      chk("hold_release_off", 32'(dout_valid[0]), 0);
      apb_write(4, 1);

      din_valid = '0;
      apb_write(20, 3);
      repeat (3) cycle();
      force dut.g_ch[0].r_cnt = 32'hFFFFFFFE;
      #1;
      release dut.g_ch[0].r_cnt;
      m_cnt[0] = 32'hFFFFFFFE;
      din_valid = 2'b01;
      repeat (3) cycle();
      din_valid = '0;
      apb_read(28, v);
      chk("cnt_saturate", v, 32'hFFFFFFFF);
      din_valid = 2'b01;
      cfg_psel = 1; cfg_penable = 0; cfg_pwrite = 1;
      cfg_paddr = 8'd4; cfg_pwdata = 3;
      cycle();
      din_valid = '0;
      cfg_penable = 1;
      cycle();
      cfg_psel = 0; cfg_penable = 0; cfg_pwrite = 0;
      apb_read(28, v);
      chk("cnt_clear_prio", v, 0);

      for (int i = 0; i < 3000; i++) begin
         din_valid  = N'($urandom);
         dout_ready = N'($urandom | $urandom);
         if ($urandom_range(7) == 0) begin
            if ($urandom_range(1) == 1) begin
               w = $urandom_range(15);
               d = $urandom;
               if (w == 1)
                  d = {30'b0, 1'($urandom_range(7) == 0),
                       1'($urandom_range(7) != 0)};
               else if (w % 4 == 2) d = $urandom_range(7);
               else if (w % 4 == 0 && $urandom_range(3) == 0)
                  d = $urandom_range(1) * 255;
               apb_write(w * 4, d);
            end else begin
               apb_read($urandom_range(63) * 4, v);
            end
         end else begin
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
